// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit FIFO: send-FSM state encodings.
package uart_tx_fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STROBE = 2'd2,
        ST_SETTLE = 2'd3
    } tx_state_e;

endpackage

// File: rtl/generic_ram.sv
// Simple dual-port RAM: one write port, one registered read port (one clk latency).
module generic_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO feeding uart_tx: valid/ready write side, baud-paced send FSM,
// selectable backpressure or drop-with-count overflow handling.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter bit          DROP_ON_FULL = 1'b0,
    parameter int unsigned CNT_WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic                  baud_x1,
    input  logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_strobe,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic [CNT_WIDTH-1:0]  drop_count
);

    localparam logic [ADDR_WIDTH:0]  PtrOne = 1;
    localparam logic [CNT_WIDTH-1:0] CntOne = 1;

    logic [ADDR_WIDTH:0]   wptr_q, rptr_q;
    logic                  wr_en, rd_en, drop;
    logic [DATA_WIDTH-1:0] rd_data;
    tx_state_e             state_q;
    logic                  overflow_q;
    logic [CNT_WIDTH-1:0]  drop_count_q;

    // Extra wrap bit distinguishes full from empty when the low bits match.
    assign full  = (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]) &&
                   (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]);
    assign empty = (wptr_q == rptr_q);
    assign level = wptr_q - rptr_q;

    assign wr_ready = DROP_ON_FULL ? 1'b1 : !full;
    assign wr_en    = wr_valid && !full && !flush;
    assign drop     = DROP_ON_FULL && wr_valid && full && !flush;
    assign rd_en    = (state_q == ST_IDLE) && baud_x1 && !empty && tx_ready && !flush;

    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (wr_en) begin
                wptr_q <= wptr_q + PtrOne;
            end
            if (flush) begin
                rptr_q <= wptr_q;
            end else if (rd_en) begin
                rptr_q <= rptr_q + PtrOne;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (drop_count_q != '1) begin
                drop_count_q <= drop_count_q + CntOne;
            end
        end
    end

    generic_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wptr_q[ADDR_WIDTH-1:0]),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rptr_q[ADDR_WIDTH-1:0]),
        .rd_data (rd_data)
    );

    // SETTLE waits an extra baud tick so uart_tx has dropped tx_ready before IDLE samples it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            tx_data   <= '0;
            tx_strobe <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (rd_en) begin
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    tx_data   <= rd_data;
                    tx_strobe <= 1'b1;
                    state_q   <= ST_STROBE;
                end
                ST_STROBE: begin
                    if (baud_x1) begin
                        tx_strobe <= 1'b0;
                        state_q   <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (baud_x1) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench: a backpressure instance (a) and a drop-mode instance (b).
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       baud = 1'b0;

    logic       flush_a = 1'b0, wr_valid_a = 1'b0, tx_ready_a = 1'b0;
    logic [7:0] wr_data_a = 8'h00;
    logic       wr_ready_a, tx_strobe_a, empty_a, full_a, overflow_a;
    logic [7:0] tx_data_a, drop_count_a;
    logic [4:0] level_a;

    logic       flush_b = 1'b0, wr_valid_b = 1'b0, tx_ready_b = 1'b0;
    logic [7:0] wr_data_b = 8'h00;
    logic       wr_ready_b, tx_strobe_b, empty_b, full_b, overflow_b;
    logic [7:0] tx_data_b;
    logic [1:0] drop_count_b;
    logic [4:0] level_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .DATA_WIDTH (8), .ADDR_WIDTH (4), .DROP_ON_FULL (1'b0), .CNT_WIDTH (8)
    ) dut_a (
        .clk (clk), .reset (reset), .flush (flush_a), .wr_data (wr_data_a),
        .wr_valid (wr_valid_a), .wr_ready (wr_ready_a), .baud_x1 (baud),
        .tx_ready (tx_ready_a), .tx_data (tx_data_a), .tx_strobe (tx_strobe_a),
        .empty (empty_a), .full (full_a), .level (level_a), .overflow (overflow_a),
        .drop_count (drop_count_a)
    );

    uart_tx_fifo #(
        .DATA_WIDTH (8), .ADDR_WIDTH (4), .DROP_ON_FULL (1'b1), .CNT_WIDTH (2)
    ) dut_b (
        .clk (clk), .reset (reset), .flush (flush_b), .wr_data (wr_data_b),
        .wr_valid (wr_valid_b), .wr_ready (wr_ready_b), .baud_x1 (baud),
        .tx_ready (tx_ready_b), .tx_data (tx_data_b), .tx_strobe (tx_strobe_b),
        .empty (empty_b), .full (full_b), .level (level_b), .overflow (overflow_b),
        .drop_count (drop_count_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_a(input logic [7:0] d);
        wr_data_a = d;
        wr_valid_a = 1'b1;
        tick();
        wr_valid_a = 1'b0;
    endtask

    // One full send cycle from IDLE; strobe must stay up until exactly one baud tick passes.
    task automatic send_one(input bit sel, input logic [7:0] exp, input string tag);
        baud = 1'b1;
        tick();
        baud = 1'b0;
        tick();
        chk({tag, "_strobe_on"}, sel ? tx_strobe_b : tx_strobe_a, 1'b1);
        chk({tag, "_data"}, sel ? tx_data_b : tx_data_a, exp);
        tick();
        chk({tag, "_strobe_held"}, sel ? tx_strobe_b : tx_strobe_a, 1'b1);
        baud = 1'b1;
        tick();
        baud = 1'b0;
        chk({tag, "_strobe_off"}, sel ? tx_strobe_b : tx_strobe_a, 1'b0);
        tick();
        baud = 1'b1;
        tick();
        baud = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        tick();
        tick();
        reset = 1'b0;
        chk("rst_wr_ready", wr_ready_a, 1'b1);
        chk("rst_tx_data", tx_data_a, 8'h00);
        chk("rst_tx_strobe", tx_strobe_a, 1'b0);
        chk("rst_empty", empty_a, 1'b1);
        chk("rst_full", full_a, 1'b0);
        chk("rst_level", level_a, 5'd0);
        chk("rst_overflow", overflow_b, 1'b0);
        chk("rst_drop_count", drop_count_b, 2'd0);

        // Basic order
        tx_ready_a = 1'b1;
        wr_a(8'h41);
        wr_a(8'h42);
        wr_a(8'h43);
        chk("basic_level", level_a, 5'd3);
        chk("basic_not_empty", empty_a, 1'b0);
        send_one(1'b0, 8'h41, "basic0");
        send_one(1'b0, 8'h42, "basic1");
        send_one(1'b0, 8'h43, "basic2");
        chk("basic_empty_after", empty_a, 1'b1);

        // Backpressure: 16 fill, 17th held until the first byte leaves
        tx_ready_a = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_data_a = 8'h10 + 8'(i);
            wr_valid_a = 1'b1;
            tick();
        end
        wr_data_a = 8'h20;
        chk("bp_full", full_a, 1'b1);
        chk("bp_level16", level_a, 5'd16);
        chk("bp_wr_ready_low", wr_ready_a, 1'b0);
        tick();
        chk("bp_held_level", level_a, 5'd16);
        baud = 1'b1;
        tick();
        baud = 1'b0;
        chk("bp_txready_gates", level_a, 5'd16);
        tx_ready_a = 1'b1;
        baud = 1'b1;
        tick();
        baud = 1'b0;
        chk("bp_deq_level", level_a, 5'd15);
        chk("bp_wr_ready_back", wr_ready_a, 1'b1);
        chk("bp_not_full", full_a, 1'b0);
        tick();
        wr_valid_a = 1'b0;
        chk("bp_17th_accepted", level_a, 5'd16);
        chk("bp_first_strobe", tx_strobe_a, 1'b1);
        chk("bp_first_data", tx_data_a, 8'h10);
        baud = 1'b1;
        tick();
        baud = 1'b0;
        tick();
        baud = 1'b1;
        tick();
        baud = 1'b0;
        for (int i = 1; i < 16; i++) begin
            send_one(1'b0, 8'h10 + 8'(i), "bp_drain");
        end
        send_one(1'b0, 8'h20, "bp_17th");
        chk("bp_empty_after", empty_a, 1'b1);

        // Simultaneous write/read, then streaming across the pointer wrap
        wr_a(8'h00);
        wr_a(8'h01);
        wr_data_a = 8'h02;
        wr_valid_a = 1'b1;
        baud = 1'b1;
        tick();
        wr_valid_a = 1'b0;
        baud = 1'b0;
        chk("simul_level", level_a, 5'd2);
        tick();
        chk("wrap0_data", tx_data_a, 8'h00);
        chk("wrap0_strobe", tx_strobe_a, 1'b1);
        baud = 1'b1;
        tick();
        baud = 1'b0;
        tick();
        baud = 1'b1;
        tick();
        baud = 1'b0;
        send_one(1'b0, 8'h01, "wrap1");
        send_one(1'b0, 8'h02, "wrap2");
        for (int i = 3; i < 10; i++) begin
            wr_a(8'(i));
            send_one(1'b0, 8'(i), "wrap_n");
        end
        chk("wrap_empty_after", empty_a, 1'b1);

        // Flush during STROBE of the first of five bytes
        for (int i = 0; i < 5; i++) begin
            wr_a(8'h50 + 8'(i));
        end
        baud = 1'b1;
        tick();
        baud = 1'b0;
        tick();
        chk("fl_level_before", level_a, 5'd4);
        flush_a = 1'b1;
        wr_data_a = 8'h99;
        wr_valid_a = 1'b1;
        tick();
        flush_a = 1'b0;
        wr_valid_a = 1'b0;
        chk("fl_level0", level_a, 5'd0);
        chk("fl_empty", empty_a, 1'b1);
        chk("fl_strobe_kept", tx_strobe_a, 1'b1);
        chk("fl_data_kept", tx_data_a, 8'h50);
        baud = 1'b1;
        tick();
        baud = 1'b0;
        tick();
        baud = 1'b1;
        tick();
        baud = 1'b0;
        for (int i = 0; i < 3; i++) begin
            baud = 1'b1;
            tick();
            baud = 1'b0;
            tick();
            tick();
            chk("fl_no_more_strobe", tx_strobe_a, 1'b0);
        end
        chk("fl_drop_count", drop_count_a, 8'd0);

        // Drop mode: 21 writes into 16 slots, counter saturates at 3
        tx_ready_b = 1'b0;
        for (int i = 0; i < 21; i++) begin
            wr_data_b = 8'h60 + 8'(i);
            wr_valid_b = 1'b1;
            tick();
            if (i == 17) chk("drop_count_mid", drop_count_b, 2'd2);
        end
        wr_valid_b = 1'b0;
        chk("drop_level16", level_b, 5'd16);
        chk("drop_full", full_b, 1'b1);
        chk("drop_overflow", overflow_b, 1'b1);
        chk("drop_count_sat", drop_count_b, 2'd3);
        chk("drop_wr_ready", wr_ready_b, 1'b1);
        tx_ready_b = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send_one(1'b1, 8'h60 + 8'(i), "drop_drain");
        end
        chk("drop_empty_after", empty_b, 1'b1);
        baud = 1'b1;
        tick();
        baud = 1'b0;
        tick();
        chk("drop_no_extra", tx_strobe_b, 1'b0);
        wr_data_b = 8'h77;
        wr_valid_b = 1'b1;
        tick();
        wr_valid_b = 1'b0;
        chk("drop_refill_level", level_b, 5'd1);
        flush_b = 1'b1;
        tick();
        flush_b = 1'b0;
        chk("drop_flush_level", level_b, 5'd0);
        chk("drop_flush_count_kept", drop_count_b, 2'd3);
        chk("drop_flush_ovf_kept", overflow_b, 1'b1);

        // Reset mid-transfer
        wr_a(8'h70);
        wr_a(8'h71);
        wr_data_b = 8'h72;
        wr_valid_b = 1'b1;
        tick();
        wr_valid_b = 1'b0;
        baud = 1'b1;
        tick();
        baud = 1'b0;
        tick();
        chk("mid_strobe_a", tx_strobe_a, 1'b1);
        chk("mid_strobe_b", tx_strobe_b, 1'b1);
        chk("mid_level_a", level_a, 5'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rmid_strobe_a", tx_strobe_a, 1'b0);
        chk("rmid_level_a", level_a, 5'd0);
        chk("rmid_wr_ready_a", wr_ready_a, 1'b1);
        chk("rmid_strobe_b", tx_strobe_b, 1'b0);
        chk("rmid_overflow_b", overflow_b, 1'b0);
        chk("rmid_drop_count_b", drop_count_b, 2'd0);
        chk("rmid_empty_b", empty_b, 1'b1);
        chk("rmid_tx_data_a", tx_data_a, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
